// File: rtl/eth_mac_ctrl_pkg.sv
// eth_mac_ctrl_pkg: shared types and constants for the MAC control
// (802.3x PAUSE) transmit path.
package eth_mac_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAUSE
  } sched_state_t;

  localparam logic [47:0] PAUSE_DA = 48'h0180C2000001;
  localparam logic [15:0] ETHERTYPE_MAC_CTRL = 16'h8808;
  localparam logic [15:0] OPCODE_PAUSE = 16'h0001;
  localparam int unsigned PAUSE_WORDS = 15;
  localparam int unsigned WIDX_W = 4;

  typedef logic [WIDX_W-1:0] word_idx_t;

  // First byte on the wire goes to bits [7:0].
  function automatic logic [31:0] wire_word(
    input logic [7:0] b0,
    input logic [7:0] b1,
    input logic [7:0] b2,
    input logic [7:0] b3
  );
    return {b3, b2, b1, b0};
  endfunction

endpackage

// File: rtl/eth_pause_frame_gen.sv
// eth_pause_frame_gen: combinational word source for a 60-byte
// PAUSE frame on a 32-bit little-endian-lane stream.
module eth_pause_frame_gen
  import eth_mac_ctrl_pkg::*;
(
  input  word_idx_t   word_idx,
  input  logic [47:0] src_mac,
  input  logic [15:0] quanta,
  output logic [31:0] tdata,
  output logic        tlast
);

  always_comb begin
    tdata = '0;
    unique case (word_idx)
      4'd0: tdata = wire_word(
        PAUSE_DA[47:40], PAUSE_DA[39:32],
        PAUSE_DA[31:24], PAUSE_DA[23:16]);
      4'd1: tdata = wire_word(
        PAUSE_DA[15:8], PAUSE_DA[7:0],
        src_mac[47:40], src_mac[39:32]);
      4'd2: tdata = wire_word(
        src_mac[31:24], src_mac[23:16],
        src_mac[15:8], src_mac[7:0]);
      4'd3: tdata = wire_word(
        ETHERTYPE_MAC_CTRL[15:8],
        ETHERTYPE_MAC_CTRL[7:0],
        OPCODE_PAUSE[15:8],
        OPCODE_PAUSE[7:0]);
      4'd4: tdata = wire_word(
        quanta[15:8], quanta[7:0],
        8'h00, 8'h00);
      default: tdata = '0;
    endcase
  end

  assign tlast = (word_idx == WIDX_W'(PAUSE_WORDS - 1));

endmodule

// File: rtl/eth_mac_pause_tx_sched.sv
// eth_mac_pause_tx_sched: merges user frames with 802.3x PAUSE
// frames on the MAC tx_axis, switching only at frame boundaries.
module eth_mac_pause_tx_sched
  import eth_mac_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  xoff,
  input  logic [47:0]           cfg_src_mac,
  input  logic [15:0]           cfg_quanta,
  input  logic [15:0]           cfg_refresh,
  output logic                  busy,
  output logic                  pause_sent
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("eth_mac_pause_tx_sched: DATA_WIDTH must be 32");
  end

  sched_state_t state;
  logic         pending;
  logic [15:0]  pend_q;
  logic         xoff_q;
  logic [15:0]  timer;
  word_idx_t    word_cnt;
  logic [47:0]  frm_src;
  logic [15:0]  frm_quanta;
  logic         pause_sent_q;

  logic [31:0]  gen_tdata;
  logic         gen_tlast;

  eth_pause_frame_gen u_gen (
    .word_idx (word_cnt),
    .src_mac  (frm_src),
    .quanta   (frm_quanta),
    .tdata    (gen_tdata),
    .tlast    (gen_tlast)
  );

  logic pause_last_hs;
  logic xoff_rise;
  logic xoff_fall;
  logic refresh_on;
  logic refresh_hit;

  assign pause_last_hs = (state == PAUSE)
                      && m_axis_tready
                      && gen_tlast;
  assign xoff_rise = xoff && !xoff_q;
  assign xoff_fall = !xoff && xoff_q;
  assign refresh_on = xoff && (cfg_refresh != 16'd0);
  assign refresh_hit = refresh_on
                    && !pause_last_hs
                    && (timer == cfg_refresh - 16'd1);

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    s_axis_tready = 1'b0;
    unique case (state)
      DATA: begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tkeep  = s_axis_tkeep;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast  = s_axis_tlast;
        m_axis_tuser  = s_axis_tuser;
        s_axis_tready = m_axis_tready;
      end
      PAUSE: begin
        m_axis_tdata  = gen_tdata;
        m_axis_tkeep  = '1;
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = gen_tlast;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);
  assign pause_sent = pause_sent_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pending      <= 1'b0;
      pend_q       <= '0;
      xoff_q       <= 1'b0;
      timer        <= '0;
      word_cnt     <= '0;
      frm_src      <= '0;
      frm_quanta   <= '0;
      pause_sent_q <= 1'b0;
    end else begin
      xoff_q       <= xoff;
      pause_sent_q <= 1'b0;

      unique case (state)
        IDLE: begin
          if (pending) begin
            frm_src    <= cfg_src_mac;
            frm_quanta <= pend_q;
            word_cnt   <= '0;
            state      <= PAUSE;
          end else if (s_axis_tvalid) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (s_axis_tvalid && m_axis_tready
              && s_axis_tlast) begin
            state <= IDLE;
          end
        end
        PAUSE: begin
          if (m_axis_tready) begin
            if (gen_tlast) begin
              word_cnt     <= '0;
              pause_sent_q <= 1'b1;
              state        <= IDLE;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A same-cycle event re-arms pending over the capture.
      if (state == IDLE && pending) begin
        pending <= 1'b0;
      end
      if (xoff_rise || refresh_hit) begin
        pending <= 1'b1;
        pend_q  <= cfg_quanta;
      end else if (xoff_fall) begin
        pending <= 1'b1;
        pend_q  <= '0;
      end

      if (!refresh_on || pause_last_hs
          || refresh_hit) begin
        timer <= '0;
      end else begin
        timer <= timer + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_eth_mac_pause_tx_sched.sv
// tb_eth_mac_pause_tx_sched: randomized scoreboard bench for the
// PAUSE scheduler against a frame-level reference model.
module tb_eth_mac_pause_tx_sched;

  localparam int S_IDLE = 0;
  localparam int S_DATA = 1;
  localparam int S_PAUSE = 2;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        u;
    logic        p;
  } beat_t;

  typedef struct {
    int st;
    bit rs;
    bit ps;
  } ctl_t;

  typedef struct {
    int          code;
    int          idx;
    logic [31:0] val;
    string       name;
  } dreq_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        xoff;
  logic [47:0] cfg_src_mac;
  logic [15:0] cfg_quanta;
  logic [15:0] cfg_refresh;
  logic        busy;
  logic        pause_sent;

  eth_mac_pause_tx_sched dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .xoff          (xoff),
    .cfg_src_mac   (cfg_src_mac),
    .cfg_quanta    (cfg_quanta),
    .cfg_refresh   (cfg_refresh),
    .busy          (busy),
    .pause_sent    (pause_sent)
  );

  always #5 clk = ~clk;

  beat_t uq[$];
  beat_t expq[$];
  ctl_t  ctlq[$];
  dreq_t dirq[$];
  int    lenq[$];

  int n_vec = 0;
  int n_fail = 0;
  int gap_pct = 0;
  int cur_len = 0;
  int widx = 0;
  beat_t fw[64];
  logic [31:0] last_pause[15];
  int npause = 0;
  int pbeat = 0;

  int          mst = S_IDLE;
  bit          mpend = 0;
  logic [15:0] mpq = '0;
  bit          mxprev = 0;
  int          mtmr = 0;
  int          mpcnt = 0;

  // Expected PAUSE frame built byte by byte as it appears on the wire.
  function automatic void push_pause(
    input logic [47:0] src,
    input logic [15:0] q
  );
    logic [47:0] da;
    logic [7:0]  b[60];
    beat_t       e;
    da = 48'h0180C2000001;
    foreach (b[i]) b[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      b[i] = da[8*(5-i) +: 8];
      b[6+i] = src[8*(5-i) +: 8];
    end
    b[12] = 8'h88;
    b[13] = 8'h08;
    b[14] = 8'h00;
    b[15] = 8'h01;
    b[16] = q[15:8];
    b[17] = q[7:0];
    for (int w = 0; w < 15; w++) begin
      e.d = {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]};
      e.k = 4'hF;
      e.l = (w == 14);
      e.u = 1'b0;
      e.p = 1'b1;
      expq.push_back(e);
    end
  endfunction

  always @(posedge clk) begin : model
    bit    tl_hs;
    bit    ev_ref;
    bit    clr;
    beat_t b;
    ctl_t  c;
    if (rst) begin
      mst = S_IDLE;
      mpend = 0;
      mxprev = 0;
      mtmr = 0;
      mpcnt = 0;
      expq.delete();
      c.st = S_IDLE;
      c.rs = 1;
      c.ps = 0;
      ctlq.push_back(c);
    end else begin
      tl_hs = 0;
      ev_ref = 0;
      clr = 0;
      case (mst)
        S_IDLE: begin
          if (mpend) begin
            push_pause(cfg_src_mac, mpq);
            clr = 1;
            mpcnt = 0;
            mst = S_PAUSE;
          end else if (s_axis_tvalid) begin
            do begin
              b = uq.pop_front();
              expq.push_back(b);
            end while (!b.l && uq.size() > 0);
            mst = S_DATA;
          end
        end
        S_DATA: begin
          if (s_axis_tvalid && m_axis_tready
              && s_axis_tlast) mst = S_IDLE;
        end
        default: begin
          if (m_axis_tready) begin
            if (mpcnt == 14) begin
              tl_hs = 1;
              mst = S_IDLE;
            end else begin
              mpcnt++;
            end
          end
        end
      endcase
      if (clr) mpend = 0;
      if (!xoff || cfg_refresh == 0 || tl_hs) begin
        mtmr = 0;
      end else if (mtmr == int'(cfg_refresh) - 1) begin
        mtmr = 0;
        ev_ref = 1;
      end else begin
        mtmr++;
      end
      if ((xoff && !mxprev) || ev_ref) begin
        mpend = 1;
        mpq = cfg_quanta;
      end else if (!xoff && mxprev) begin
        mpend = 1;
        mpq = 16'h0000;
      end
      mxprev = xoff;
      c.st = mst;
      c.rs = 0;
      c.ps = tl_hs;
      ctlq.push_back(c);
    end
  end

  always @(negedge clk) begin : monitor
    ctl_t        c;
    beat_t       e;
    dreq_t       r;
    logic [3:0]  act;
    logic [3:0]  ex;
    logic [31:0] av;
    bit          ok;
    bit          prev_stall;
    logic [32:0] prev_dl;
    if (ctlq.size() > 0) begin
      c = ctlq.pop_front();
      ex[3] = (c.st == S_PAUSE) ? 1'b1 :
              (c.st == S_DATA) ? s_axis_tvalid : 1'b0;
      ex[2] = (c.st != S_IDLE);
      ex[1] = (c.st == S_DATA) ? m_axis_tready : 1'b0;
      ex[0] = c.ps;
      act = {m_axis_tvalid, busy, s_axis_tready, pause_sent};
      n_vec++;
      if (act !== ex) begin
        n_fail++;
        $display("FAIL ctrl{v,busy,srdy,ps} act=%b exp=%b t=%0t",
                 act, ex, $time);
      end
      if (c.rs) begin
        n_vec++;
        if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast,
             m_axis_tuser} !== 38'd0) begin
          n_fail++;
          $display("FAIL reset_outs act=%h/%h/%b/%b exp=0",
                   m_axis_tdata, m_axis_tkeep,
                   m_axis_tlast, m_axis_tuser);
        end
      end
    end
    if (prev_stall) begin
      n_vec++;
      if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast}
          !== {1'b1, prev_dl}) begin
        n_fail++;
        $display("FAIL stall_stable act=%b/%h/%b exp=1/%h/%b",
                 m_axis_tvalid, m_axis_tdata, m_axis_tlast,
                 prev_dl[32:1], prev_dl[0]);
      end
    end
    prev_stall = !rst && m_axis_tvalid && !m_axis_tready;
    prev_dl = {m_axis_tdata, m_axis_tlast};
    if (rst) begin
      pbeat = 0;
      prev_stall = 0;
    end else if (m_axis_tvalid && m_axis_tready) begin
      n_vec++;
      if (expq.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected act=%h exp=none",
                 m_axis_tdata);
      end else begin
        e = expq.pop_front();
        if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast,
             m_axis_tuser} !== {e.d, e.k, e.l, e.u}) begin
          n_fail++;
          $display("FAIL beat act=%h/%h/%b/%b exp=%h/%h/%b/%b",
                   m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                   m_axis_tuser, e.d, e.k, e.l, e.u);
        end
        if (e.p) begin
          if (pbeat < 15) last_pause[pbeat] = m_axis_tdata;
          pbeat++;
          if (e.l) begin
            npause++;
            pbeat = 0;
          end
        end
      end
    end
    while (dirq.size() > 0) begin
      r = dirq.pop_front();
      n_vec++;
      case (r.code)
        0: begin
          av = last_pause[r.idx];
          ok = (av === r.val);
        end
        1: begin
          av = npause;
          ok = (npause >= int'(r.val));
        end
        2: begin
          av = npause;
          ok = (npause == int'(r.val));
        end
        default: begin
          av = 0;
          ok = 0;
        end
      endcase
      if (!ok) begin
        n_fail++;
        $display("FAIL %s act=%h exp=%h", r.name, av, r.val);
      end
    end
  end

  initial begin : driver
    bit         hs;
    logic [3:0] kf;
    s_axis_tvalid = 0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tlast = 0;
    s_axis_tuser = 0;
    forever begin
      @(negedge clk);
      hs = s_axis_tvalid && s_axis_tready && !rst;
      @(posedge clk);
      #1;
      if (hs) begin
        widx++;
        if (widx == cur_len) cur_len = 0;
      end
      if (cur_len == 0 && lenq.size() > 0) begin
        cur_len = lenq.pop_front();
        widx = 0;
        kf = 4'hF;
        kf = kf >> $urandom_range(3);
        for (int i = 0; i < cur_len; i++) begin
          fw[i].d = $urandom;
          fw[i].l = (i == cur_len - 1);
          fw[i].k = fw[i].l ? kf : 4'hF;
          fw[i].u = fw[i].l ? 1'($urandom_range(1)) : 1'b0;
          fw[i].p = 1'b0;
          uq.push_back(fw[i]);
        end
      end
      if (cur_len != 0) begin
        if (!s_axis_tvalid || hs)
          s_axis_tvalid = ($urandom_range(99) >= gap_pct);
        s_axis_tdata = fw[widx].d;
        s_axis_tkeep = fw[widx].k;
        s_axis_tlast = fw[widx].l;
        s_axis_tuser = fw[widx].u;
      end else begin
        s_axis_tvalid = 0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic req(input int code, input int idx,
                     input logic [31:0] v, input string nm);
    dreq_t r;
    r.code = code;
    r.idx = idx;
    r.val = v;
    r.name = nm;
    dirq.push_back(r);
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    do begin
      cyc(1);
      t++;
    end while (!(mst == S_IDLE && !mpend && expq.size() == 0
                 && uq.size() == 0 && lenq.size() == 0
                 && cur_len == 0) && t < 5000);
    if (t >= 5000) req(3, 0, 0, {nm, "_timeout"});
    cyc(3);
  endtask

  task automatic wait_until_widx(input int len, input int w,
                                 input string nm);
    int t;
    t = 0;
    while (!(cur_len == len && widx >= w) && t < 2000) begin
      cyc(1);
      t++;
    end
    if (t >= 2000) req(3, 0, 0, {nm, "_timeout"});
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : control
    int base;
    int t;
    rst = 1;
    xoff = 0;
    cfg_src_mac = 48'h5A5152535455;
    cfg_quanta = 16'hFFFF;
    cfg_refresh = 16'd0;
    m_axis_tready = 0;
    cyc(3);
    rst = 0;

    m_axis_tready = 1;
    lenq.push_back(16);
    drain("passthrough");
    req(2, 0, 0, "pt_no_pause");

    xoff = 1;
    drain("xoff");
    req(0, 0, 32'h00C28001, "xoff_w0");
    req(0, 1, 32'h515A0100, "xoff_w1");
    req(0, 2, 32'h55545352, "xoff_w2");
    req(0, 3, 32'h01000888, "xoff_w3");
    req(0, 4, 32'h0000FFFF, "xoff_w4");
    req(0, 14, 32'h0, "xoff_w14");
    req(2, 0, 1, "xoff_count");

    xoff = 0;
    drain("xon");
    req(0, 4, 32'h0, "xon_w4");
    req(2, 0, 2, "xon_count");

    lenq.push_back(25);
    wait_until_widx(25, 3, "boundary_w3");
    xoff = 1;
    drain("boundary");
    req(0, 4, 32'h0000FFFF, "boundary_w4");
    req(2, 0, 3, "boundary_count");
    xoff = 0;
    drain("boundary_xon");

    cfg_refresh = 16'd200;
    base = npause;
    xoff = 1;
    cyc(700);
    req(1, 0, base + 3, "refresh_count");
    xoff = 0;
    drain("refresh_xon");
    req(0, 4, 32'h0, "refresh_xon_w4");
    base = npause;
    cyc(500);
    req(2, 0, base, "after_xon_quiet");
    cfg_refresh = 16'd0;

    gap_pct = 30;
    cfg_refresh = 16'($urandom_range(40, 90));
    for (int i = 0; i < 3000; i++) begin
      m_axis_tready = 1'($urandom_range(1));
      if ($urandom_range(149) == 0) xoff = ~xoff;
      if ($urandom_range(99) == 0) cfg_quanta = 16'($urandom);
      if ($urandom_range(199) == 0)
        cfg_src_mac = {16'($urandom), 32'($urandom)};
      if (lenq.size() == 0 && $urandom_range(19) == 0)
        lenq.push_back($urandom_range(1, 30));
      cyc(1);
    end
    xoff = 0;
    cfg_refresh = 16'd0;
    m_axis_tready = 1;
    gap_pct = 0;
    drain("random");

    cfg_quanta = 16'hFFFF;
    xoff = 1;
    t = 0;
    while (pbeat < 7 && t < 200) begin
      cyc(1);
      t++;
    end
    if (t >= 200) req(3, 0, 0, "mid_pause_timeout");
    rst = 1;
    xoff = 0;
    cyc(2);
    rst = 0;
    base = npause;
    cyc(20);
    req(2, 0, base, "post_reset_no_pause");
    xoff = 1;
    drain("post_reset");
    req(0, 0, 32'h00C28001, "post_reset_w0");
    req(0, 4, 32'h0000FFFF, "post_reset_w4");
    req(2, 0, base + 1, "post_reset_count");
    xoff = 0;
    drain("final");
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_fail);
    $finish;
  end

endmodule
